// File: rtl/alu_pkg.sv
// Shared opcode constants and controller state encoding for the serial nibble ALU.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  function automatic logic op_is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu16_serial_ctrl_if.sv
// Request/response bundle between a client and the serial nibble ALU controller.
interface alu16_serial_ctrl_if #(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [2:0]   in_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_cout;
  logic         out_zero;
  logic         out_set;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_result, out_cout, out_zero, out_set
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_result, out_cout, out_zero, out_set
  );

endinterface

// File: rtl/alu16_serial_ctrl_alu4.sv
// 4-bit ALU slice: AND/OR/ADD/SUB/SLT with carry-in, B inversion on op[2], less input.
module ALU4Bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] op,
  input  logic       cin,
  input  logic       less,
  output logic [3:0] result,
  output logic       cout,
  output logic       set
);

  logic [3:0] bx;
  logic [4:0] sum;

  always_comb begin
    bx  = op[2] ? ~b : b;
    sum = {1'b0, a} + {1'b0, bx} + {4'b0000, cin};
    unique case (op[1:0])
      2'b00:   result = a & b;
      2'b01:   result = a | b;
      2'b10:   result = sum[3:0];
      default: result = {3'b000, less};
    endcase
    cout = sum[4];
    set  = sum[3];
  end

endmodule

// File: rtl/alu16_serial_ctrl.sv
// Serial W-bit ALU: one 4-bit slice iterated over NIBBLES cycles, LSB nibble first.
module alu16_serial_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  alu16_serial_ctrl_if.slave  bus
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, b_q, acc_q, res_q;
  logic [2:0]      op_q;
  logic [IW-1:0]   idx_q;
  logic            carry_q;
  logic            cout_q, zero_q, set_q;

  logic [31:0]     base;
  logic [3:0]      slice_res;
  logic            slice_cout, slice_set;
  logic            accept, last;
  logic [W-1:0]    merged, fin_res;
  logic            fin_cout, fin_set;

  assign accept = bus.in_valid && (state_q == S_IDLE);
  assign last   = (idx_q == IW'(NIBBLES - 1));
  assign base   = 32'(idx_q) << 2;

  ALU4Bit u_slice (
    .a      (a_q[base +: 4]),
    .b      (b_q[base +: 4]),
    .op     (op_q),
    .cin    (carry_q),
    .less   (1'b0),
    .result (slice_res),
    .cout   (slice_cout),
    .set    (slice_set)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept)        state_d = S_RUN;
      S_RUN:   if (last)          state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == S_IDLE);
    bus.out_valid = (state_q == S_DONE);
  end

  // The top nibble is merged combinationally so the final edge can publish the whole word.
  always_comb begin
    merged            = acc_q;
    merged[base +: 4] = slice_res;
    fin_res           = '0;
    unique case (op_q)
      OP_AND, OP_OR, OP_ADD, OP_SUB: fin_res = merged;
      OP_SLT:                        fin_res = {{(W-1){1'b0}}, slice_set};
      default:                       fin_res = '0;
    endcase
    fin_cout = op_is_arith(op_q) ? slice_cout : 1'b0;
    fin_set  = ((op_q == OP_SUB) || (op_q == OP_SLT)) ? slice_set : 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      set_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= bus.in_a;
      b_q     <= bus.in_b;
      op_q    <= bus.in_op;
      idx_q   <= '0;
      carry_q <= bus.in_op[2];
    end else if (state_q == S_RUN) begin
      acc_q   <= merged;
      carry_q <= slice_cout;
      if (last) begin
        idx_q  <= '0;
        res_q  <= fin_res;
        cout_q <= fin_cout;
        set_q  <= fin_set;
        zero_q <= (fin_res == '0);
      end else begin
        idx_q  <= idx_q + 1'b1;
      end
    end
  end

  assign bus.out_result = res_q;
  assign bus.out_cout   = cout_q;
  assign bus.out_zero   = zero_q;
  assign bus.out_set    = set_q;

endmodule

// File: tb/tb_alu16_serial_ctrl.sv
// Self-checking bench for alu16_serial_ctrl: directed corners plus random ops vs a word-level model.
module tb_alu16_serial_ctrl;
  import alu_pkg::*;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W       = 4 * NIBBLES;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  alu16_serial_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

  alu16_serial_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         cout;
    logic         zero;
    logic         set;
  } exp_t;

  // Word-level reference: whole-operand arithmetic, no nibble iteration.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t       e;
    logic [W:0] s;
    logic [W-1:0] d;
    e.res  = '0;
    e.cout = 1'b0;
    e.set  = 1'b0;
    d      = a - b;
    case (op)
      OP_AND: e.res = a & b;
      OP_OR:  e.res = a | b;
      OP_ADD: begin
        s      = {1'b0, a} + {1'b0, b};
        e.res  = s[W-1:0];
        e.cout = s[W];
      end
      OP_SUB: begin
        e.res  = d;
        e.cout = (a >= b);
        e.set  = d[W-1];
      end
      OP_SLT: begin
        e.set    = d[W-1];
        e.res[0] = d[W-1];
      end
      default: ;
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check({tag, ".result"}, bus.out_result, e.res);
    check({tag, ".cout"},   W'(bus.out_cout), W'(e.cout));
    check({tag, ".zero"},   W'(bus.out_zero), W'(e.zero));
    check({tag, ".set"},    W'(bus.out_set),  W'(e.set));
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_wait", W'(bus.in_ready), W'(1));
  endtask

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input bit pulse, input string tag);
    exp_t e;
    int   n;
    e = model(op, a, b);
    wait_ready();
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_a     = W'($urandom);
    bus.in_b     = W'($urandom);
    bus.in_op    = 3'($urandom);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, ".latency"}, W'(n), W'(NIBBLES));
    check_outputs(tag, e);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.in_a     = W'($urandom);
      bus.in_op    = 3'($urandom);
      @(posedge clk); #1;
      check({tag, ".hold_valid"}, W'(bus.out_valid), W'(1));
      check({tag, ".hold_result"}, bus.out_result, e.res);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, ".release_valid"}, W'(bus.out_valid), W'(0));
    check({tag, ".release_ready"}, W'(bus.in_ready), W'(1));
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return W'(1);
      default: return W'($urandom);
    endcase
  endfunction

  task automatic back_to_back(input int count);
    exp_t q[$];
    exp_t e;
    int   got  = 0;
    int   last = -1;
    bit   acc;
    bus.in_a      = rand_operand();
    bus.in_b      = rand_operand();
    bus.in_op     = 3'($urandom);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 400 && got < count; cyc++) begin
      acc = 1'b0;
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          check("b2b.spurious", W'(1), W'(0));
        end else begin
          e = q.pop_front();
          check_outputs("b2b", e);
        end
        if (last >= 0) check("b2b.spacing", W'(cyc - last), W'(NIBBLES + 2));
        last = cyc;
        got++;
      end
      if (bus.in_ready) begin
        q.push_back(model(bus.in_op, bus.in_a, bus.in_b));
        acc = 1'b1;
      end
      @(posedge clk); #1;
      if (acc) begin
        bus.in_a  = rand_operand();
        bus.in_b  = rand_operand();
        bus.in_op = 3'($urandom);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("b2b.count", W'(got), W'(count));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_op     = '0;
    bus.out_ready = 1'b0;
    reset_n       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.ready",  W'(bus.in_ready),  W'(1));
    check("rst.valid",  W'(bus.out_valid), W'(0));
    check_outputs("rst", '{res: '0, cout: 1'b0, zero: 1'b0, set: 1'b0});
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst.ready_after", W'(bus.in_ready), W'(1));

    run_op(OP_ADD, 16'h00FF, 16'h0001, 0, 1'b0, "add_00ff");
    run_op(OP_ADD, 16'hFFFF, 16'h0001, 0, 1'b0, "add_ffff");
    run_op(OP_SLT, 16'h0003, 16'h0005, 0, 1'b0, "slt_3_5");
    run_op(OP_SLT, 16'h0005, 16'h0003, 0, 1'b0, "slt_5_3");
    run_op(OP_SUB, 16'h1234, 16'h1234, 10, 1'b1, "sub_hold");
    run_op(3'b011, 16'hABCD, 16'h1111, 0, 1'b0, "reserved_011");
    run_op(3'b101, 16'hFFFF, 16'hFFFF, 0, 1'b0, "reserved_101");
    run_op(OP_OR, 16'h1234, 16'h8000, 0, 1'b0, "or_pre_reset");

    // Abort an AND in its second RUN cycle; nothing of it may surface.
    wait_ready();
    bus.in_a     = 16'hF0F0;
    bus.in_b     = 16'hFF00;
    bus.in_op    = OP_AND;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("abort.ready", W'(bus.in_ready),  W'(1));
    check("abort.valid", W'(bus.out_valid), W'(0));
    check_outputs("abort", '{res: '0, cout: 1'b0, zero: 1'b0, set: 1'b0});
    #3;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("abort.ready_after", W'(bus.in_ready), W'(1));
    check("abort.no_valid",    W'(bus.out_valid), W'(0));
    run_op(OP_AND, 16'hF0F0, 16'hFF00, 0, 1'b0, "and_after_abort");

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom), rand_operand(), rand_operand(),
             $urandom_range(0, 3), 1'b1, "rand");
    end

    back_to_back(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
